// File: rtl/video_layer_mux.sv
// -----------------------------------------------------------------------------
// video_layer_mux
//
// Purpose:
//   This is an N-layer pixel compositor that sits between the pixel pipeline
//   and the TMDS encoder. For each pixel it picks the highest-priority active
//   overlay layer (layer 0 is highest) on top of a base pixel. Each layer has
//   enable, blink and blend controls. These controls are shadowed and only
//   take effect at frame start.
//
// Optional feature:
//   VIDEO_LAYER_BLEND_EN  When defined, a winning layer whose shadowed blend
//                         bit is set is mixed 50/50 with the base pixel, one
//                         colour channel at a time. When undefined, the blend
//                         controls are ignored and every layer is opaque.
//
// Ports:
//   clk_in           pixel clock
//   rst_n_in         synchronous active-low reset
//   valid_in         pixel qualifier
//   frame_start_in   marks the first pixel of a frame (when valid_in is high)
//   base_pixel_in    background pixel, 3*CH_W bits
//   layer_hit_in     bit i is set when layer i covers this pixel
//   layer_color_in   colour of layer i, at [i*3*CH_W +: 3*CH_W]
//   layer_en_in      per-layer enable (shadowed)
//   layer_blink_in   per-layer blink (shadowed)
//   layer_blend_in   per-layer 50% blend (shadowed, used only with the macro)
//   valid_out        valid_in delayed by 3 cycles
//   frame_start_out  frame_start_in delayed by 3 cycles
//   pixel_out        composited pixel; holds its value on invalid cycles
//   layer_id_out     index of the winning layer; NUM_LAYERS means base
// -----------------------------------------------------------------------------
module video_layer_mux #(
    parameter int NUM_LAYERS   = 6,
    parameter int CH_W         = 8,
    parameter int BLINK_FRAMES = 15
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic                                  valid_in,
    input  logic                                  frame_start_in,
    input  logic [3*CH_W-1:0]                     base_pixel_in,
    input  logic [NUM_LAYERS-1:0]                 layer_hit_in,
    input  logic [NUM_LAYERS*3*CH_W-1:0]          layer_color_in,
    input  logic [NUM_LAYERS-1:0]                 layer_en_in,
    input  logic [NUM_LAYERS-1:0]                 layer_blink_in,
    input  logic [NUM_LAYERS-1:0]                 layer_blend_in,
    output logic                                  valid_out,
    output logic                                  frame_start_out,
    output logic [3*CH_W-1:0]                     pixel_out,
    output logic [$clog2(NUM_LAYERS+1)-1:0]       layer_id_out
);

    localparam int PIX_W = 3 * CH_W;
    localparam int ID_W  = $clog2(NUM_LAYERS + 1);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // ------------------------------------------------------------------
    // Frame-start shadow controls and the blink timebase
    // ------------------------------------------------------------------
    logic                  frame_go;
    logic [NUM_LAYERS-1:0] en_q, blink_q;
    logic [NUM_LAYERS-1:0] en_cur, blink_cur, blend_cur;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    // phase_q is the phase that the next frame will use. frame_phase_q is
    // the phase of the frame currently in progress. Because of this split,
    // a frame displays the phase from before the frame-start update.
    logic                  phase_q, phase_d, frame_phase_q, phase_cur;
    logic [NUM_LAYERS-1:0] hit_eff;

    assign frame_go = valid_in & frame_start_in;

    // The frame-start pixel itself already sees the newly loaded controls.
    assign en_cur    = frame_go ? layer_en_in    : en_q;
    assign blink_cur = frame_go ? layer_blink_in : blink_q;
    assign phase_cur = frame_go ? phase_q        : frame_phase_q;

`ifdef VIDEO_LAYER_BLEND_EN
    logic [NUM_LAYERS-1:0] blend_q;

    assign blend_cur = frame_go ? layer_blend_in : blend_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            blend_q <= '0;
        end else if (frame_go) begin
            blend_q <= layer_blend_in;
        end
    end
`else
    logic unused_blend;

    assign unused_blend = ^layer_blend_in;
    assign blend_cur    = '0;
`endif

    always_comb begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        phase_d     = phase_q;
        if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            en_q          <= '0;
            blink_q       <= '0;
            frame_cnt_q   <= '0;
            phase_q       <= 1'b1;
            frame_phase_q <= 1'b1;
        end else if (frame_go) begin
            en_q          <= layer_en_in;
            blink_q       <= layer_blink_in;
            frame_cnt_q   <= frame_cnt_d;
            phase_q       <= phase_d;
            frame_phase_q <= phase_q;
        end
    end

    assign hit_eff = layer_hit_in & en_cur & (~blink_cur | {NUM_LAYERS{phase_cur}});

    // ------------------------------------------------------------------
    // S1: register inputs and the effective hit mask
    // ------------------------------------------------------------------
    logic                        s1_valid_q, s1_fs_q;
    logic [PIX_W-1:0]            s1_base_q;
    logic [NUM_LAYERS*PIX_W-1:0] s1_color_q;
    logic [NUM_LAYERS-1:0]       s1_hit_q, s1_blend_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s1_fs_q    <= 1'b0;
            s1_base_q  <= '0;
            s1_color_q <= '0;
            s1_hit_q   <= '0;
            s1_blend_q <= '0;
        end else begin
            s1_valid_q <= valid_in;
            s1_fs_q    <= frame_start_in;
            s1_base_q  <= base_pixel_in;
            s1_color_q <= layer_color_in;
            s1_hit_q   <= hit_eff;
            s1_blend_q <= blend_cur;
        end
    end

    // ------------------------------------------------------------------
    // S2: priority select, where the lowest set index wins
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  win_id_d;
    logic [PIX_W-1:0] win_pix_d;
    logic             win_blend_d;

    always_comb begin
        win_id_d    = ID_W'(NUM_LAYERS);
        win_pix_d   = s1_base_q;
        win_blend_d = 1'b0;
        // Scan downward so that the last match, which is the lowest index, wins.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_hit_q[i]) begin
                win_id_d    = ID_W'(i);
                win_pix_d   = s1_color_q[i*PIX_W +: PIX_W];
                win_blend_d = s1_blend_q[i];
            end
        end
    end

    logic             s2_valid_q, s2_fs_q, s2_blend_q;
    logic [PIX_W-1:0] s2_pix_q, s2_base_q;
    logic [ID_W-1:0]  s2_id_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            s2_valid_q <= 1'b0;
            s2_fs_q    <= 1'b0;
            s2_blend_q <= 1'b0;
            s2_pix_q   <= '0;
            s2_base_q  <= '0;
            s2_id_q    <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_fs_q    <= s1_fs_q;
            s2_blend_q <= win_blend_d;
            s2_pix_q   <= win_pix_d;
            s2_base_q  <= s1_base_q;
            s2_id_q    <= win_id_d;
        end
    end

    // ------------------------------------------------------------------
    // S3: optional 50/50 blend, then the output registers
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] blend_pix;
    logic [PIX_W-1:0] out_pix_d;

    // Halving both operands before adding means the sum cannot overflow CH_W.
    always_comb begin
        blend_pix = '0;
        for (int c = 0; c < 3; c++) begin
            blend_pix[c*CH_W +: CH_W] = (s2_pix_q[c*CH_W +: CH_W] >> 1)
                                      + (s2_base_q[c*CH_W +: CH_W] >> 1);
        end
        out_pix_d = s2_blend_q ? blend_pix : s2_pix_q;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid_out       <= 1'b0;
            frame_start_out <= 1'b0;
            pixel_out       <= '0;
            layer_id_out    <= '0;
        end else begin
            valid_out       <= s2_valid_q;
            frame_start_out <= s2_fs_q;
            if (s2_valid_q) begin
                pixel_out    <= out_pix_d;
                layer_id_out <= s2_id_q;
            end
        end
    end

endmodule

// File: tb/tb_video_layer_mux.sv
// -----------------------------------------------------------------------------
// tb_video_layer_mux
//
// Directed bench for video_layer_mux, built with NUM_LAYERS=6, CH_W=8 and
// BLINK_FRAMES=2. Each stimulus cycle carries the pixel and layer id that the
// output should show for it 3 cycles later. Those expectations are held in a
// queue, and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_video_layer_mux;

    localparam int NL = 6;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          valid_in;
    logic          frame_start_in;
    logic [23:0]   base_pixel_in;
    logic [NL-1:0] layer_hit_in;
    logic [NL*24-1:0] layer_color_in;
    logic [NL-1:0] layer_en_in;
    logic [NL-1:0] layer_blink_in;
    logic [NL-1:0] layer_blend_in;
    logic          valid_out;
    logic          frame_start_out;
    logic [23:0]   pixel_out;
    logic [2:0]    layer_id_out;

    video_layer_mux #(
        .NUM_LAYERS   (NL),
        .CH_W         (8),
        .BLINK_FRAMES (2)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .valid_in        (valid_in),
        .frame_start_in  (frame_start_in),
        .base_pixel_in   (base_pixel_in),
        .layer_hit_in    (layer_hit_in),
        .layer_color_in  (layer_color_in),
        .layer_en_in     (layer_en_in),
        .layer_blink_in  (layer_blink_in),
        .layer_blend_in  (layer_blend_in),
        .valid_out       (valid_out),
        .frame_start_out (frame_start_out),
        .pixel_out       (pixel_out),
        .layer_id_out    (layer_id_out)
    );

    always #5 clk_in = ~clk_in;

`ifdef VIDEO_LAYER_BLEND_EN
    localparam logic [23:0] BLEND_EXP = 24'h7F007F;
`else
    localparam logic [23:0] BLEND_EXP = 24'hFF0000;
`endif

    typedef struct packed {
        logic        v;
        logic        fs;
        logic [23:0] pix;
        logic [2:0]  id;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] hold_pix;
    logic [2:0]  hold_id;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and check the cycle that was driven 3 cycles earlier.
    task automatic cyc(input logic v, input logic fs, input logic [NL-1:0] hit,
                       input logic [23:0] exp_pix, input logic [2:0] exp_id);
        exp_t e;
        valid_in       = v;
        frame_start_in = fs;
        layer_hit_in   = hit;
        @(posedge clk_in);
        #1;
        if (v) begin
            hold_pix = exp_pix;
            hold_id  = exp_id;
        end
        e.v   = v;
        e.fs  = fs;
        e.pix = hold_pix;
        e.id  = hold_id;
        exp_q.push_back(e);
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            chk("valid_out",       32'(valid_out),       32'(e.v));
            chk("frame_start_out", 32'(frame_start_out), 32'(e.fs));
            chk("pixel_out",       32'(pixel_out),       32'(e.pix));
            chk("layer_id_out",    32'(layer_id_out),    32'(e.id));
        end
    endtask

    task automatic do_reset();
        rst_n_in       = 1'b0;
        valid_in       = 1'b1;
        frame_start_in = 1'b1;
        repeat (5) begin
            @(posedge clk_in);
            #1;
            chk("rst valid_out",       32'(valid_out),       32'd0);
            chk("rst frame_start_out", 32'(frame_start_out), 32'd0);
            chk("rst pixel_out",       32'(pixel_out),       32'd0);
            chk("rst layer_id_out",    32'(layer_id_out),    32'd0);
        end
        rst_n_in       = 1'b1;
        valid_in       = 1'b0;
        frame_start_in = 1'b0;
        exp_q.delete();
        hold_pix = '0;
        hold_id  = '0;
    endtask

    task automatic drain();
        repeat (2) cyc(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        rst_n_in       = 1'b0;
        valid_in       = 1'b0;
        frame_start_in = 1'b0;
        base_pixel_in  = 24'h123456;
        layer_hit_in   = '0;
        layer_en_in    = 6'h3F;
        layer_blink_in = '0;
        layer_blend_in = '0;
        layer_color_in[0*24 +: 24] = 24'hABCDEF;
        layer_color_in[1*24 +: 24] = 24'h111111;
        layer_color_in[2*24 +: 24] = 24'hFF0000;
        layer_color_in[3*24 +: 24] = 24'h00FF00;
        layer_color_in[4*24 +: 24] = 24'h444444;
        layer_color_in[5*24 +: 24] = 24'h0000AA;
        hold_pix = '0;
        hold_id  = '0;

        // Reset. The enable shadow stays 0 until the first frame start, so only the base shows.
        do_reset();
        cyc(1, 0, 6'h3F, 24'h123456, 3'd6);
        cyc(1, 0, 6'h01, 24'h123456, 3'd6);

        // Priority, with gaps in valid that must hold the last pixel.
        cyc(1, 1, 6'b001100, 24'hFF0000, 3'd2);
        cyc(0, 0, 6'b000001, 24'h000000, 3'd0);
        cyc(0, 0, 6'b000001, 24'h000000, 3'd0);
        cyc(1, 0, 6'b001000, 24'h00FF00, 3'd3);
        cyc(1, 0, 6'b000000, 24'h123456, 3'd6);
        cyc(1, 0, 6'b110000, 24'h444444, 3'd4);
        cyc(1, 0, 6'b100000, 24'h0000AA, 3'd5);
        cyc(1, 0, 6'b111111, 24'hABCDEF, 3'd0);

        // Shadowing: control changes take effect only from the next valid frame-start pixel.
        layer_en_in = 6'h00;
        cyc(1, 0, 6'b000100, 24'hFF0000, 3'd2);
        cyc(0, 0, 6'b000100, 24'h000000, 3'd0);
        cyc(1, 0, 6'b000100, 24'hFF0000, 3'd2);
        cyc(1, 1, 6'b000100, 24'h123456, 3'd6);
        cyc(1, 0, 6'b000100, 24'h123456, 3'd6);
        layer_en_in = 6'h04;
        cyc(1, 0, 6'b000100, 24'h123456, 3'd6);
        cyc(0, 1, 6'b000100, 24'h000000, 3'd0);
        cyc(1, 0, 6'b000100, 24'h123456, 3'd6);
        cyc(1, 1, 6'b000100, 24'hFF0000, 3'd2);
        cyc(1, 0, 6'b001000, 24'h123456, 3'd6);
        drain();

        // Blink with a 2-frame half period. Layer 0 blinks; layer 1 sits behind it.
        do_reset();
        layer_en_in    = 6'b000011;
        layer_blink_in = 6'b000001;
        cyc(1, 0, 6'b000011, 24'h123456, 3'd6);
        cyc(1, 1, 6'b000011, 24'hABCDEF, 3'd0);
        cyc(1, 0, 6'b000011, 24'hABCDEF, 3'd0);
        cyc(1, 1, 6'b000011, 24'hABCDEF, 3'd0);
        cyc(1, 0, 6'b000011, 24'hABCDEF, 3'd0);
        cyc(1, 1, 6'b000011, 24'h111111, 3'd1);
        cyc(1, 0, 6'b000011, 24'h111111, 3'd1);
        cyc(1, 1, 6'b000011, 24'h111111, 3'd1);
        drain();
        // Reset during frame 3. Visibility comes back, and back-to-back starts each count as a frame.
        do_reset();
        cyc(1, 1, 6'b000011, 24'hABCDEF, 3'd0);
        cyc(1, 0, 6'b000011, 24'hABCDEF, 3'd0);
        cyc(1, 1, 6'b000011, 24'hABCDEF, 3'd0);
        cyc(1, 1, 6'b000011, 24'h111111, 3'd1);
        cyc(1, 1, 6'b000011, 24'h111111, 3'd1);
        cyc(1, 1, 6'b000011, 24'hABCDEF, 3'd0);
        cyc(1, 1, 6'b000011, 24'hABCDEF, 3'd0);
        cyc(1, 1, 6'b000011, 24'h111111, 3'd1);
        cyc(1, 0, 6'b000011, 24'h111111, 3'd1);

        // Blend on layer 2 only. Non-blend layers stay opaque.
        layer_en_in    = 6'h3F;
        layer_blink_in = 6'h00;
        layer_blend_in = 6'b000100;
        base_pixel_in  = 24'h0000FF;
        cyc(1, 1, 6'b000100, BLEND_EXP,   3'd2);
        cyc(1, 0, 6'b001000, 24'h00FF00, 3'd3);
        cyc(1, 0, 6'b000101, 24'hABCDEF, 3'd0);
        cyc(1, 0, 6'b000000, 24'h0000FF, 3'd6);
        layer_blend_in = 6'b000000;
        cyc(1, 0, 6'b000100, BLEND_EXP,   3'd2);
        cyc(1, 1, 6'b000100, 24'hFF0000, 3'd2);

        // Random valid/frame_start stream on the sideband, with no hits.
        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'b000000,
                24'h0000FF, 3'd6);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
